// File: rtl/sw_debounce_irq_ctrl.sv
// Switch debouncer with a tick prescaler, edge capture and a level interrupt,
// exposed as a four-word Avalon-MM register slave.
module sw_debounce_irq_ctrl #(
    parameter int          WIDTH        = 8,
    parameter int          STABLE_TICKS = 4,
    parameter logic [15:0] PRESC_RST    = 16'd999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_TICKS);

    logic [WIDTH-1:0]      sync1_q, sync2_q;
    logic [WIDTH-1:0]      deb_q, deb_d;
    logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      edge_q, edge_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      clr_bits;
    logic [15:0]           presc_q, presc_d;
    logic [15:0]           reload_q, reload_d;
    logic                  irq_q, irq_d;
    logic [31:0]           rd_q, rd_d;
    logic                  tick;
    logic                  unused_wdata;

    // Only the low bits of writedata reach registers for narrow WIDTH.
    assign unused_wdata = ^writedata;

    always_comb begin
        tick     = (presc_q == 16'd0);
        reload_d = reload_q;
        mask_d   = mask_q;
        clr_bits = '0;
        if (write) begin
            case (address)
                2'd1:    mask_d   = writedata[WIDTH-1:0];
                2'd2:    reload_d = writedata[15:0];
                2'd3:    clr_bits = writedata[WIDTH-1:0];
                default: ;
            endcase
        end

        // A reload write restarts the count on the same edge.
        if (write && address == 2'd2) begin
            presc_d = writedata[15:0];
        end else if (tick) begin
            presc_d = reload_q;
        end else begin
            presc_d = presc_q - 16'd1;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] + 4'd1 == STABLE_CNT) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
        // A fresh edge wins over a simultaneous write-1-to-clear.
        edge_d = (edge_q & ~clr_bits) | (deb_d ^ deb_q);
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        rd_d = rd_q;
        if (read) begin
            case (address)
                2'd0:    rd_d = 32'(deb_q);
                2'd1:    rd_d = 32'(mask_q);
                2'd2:    rd_d = {16'd0, reload_q};
                default: rd_d = 32'(edge_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            presc_q  <= PRESC_RST;
            reload_q <= PRESC_RST;
            irq_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
            rd_q     <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Directed bench for sw_debounce_irq_ctrl: register access, debounce timing,
// glitch rejection, interrupt path, clear/set collision and reset mid-count.
module tb_sw_debounce_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;
    logic [31:0] rdata;
    int          n_checks = 0;
    int          n_errors = 0;

    sw_debounce_irq_ctrl #(
        .WIDTH(8),
        .STABLE_TICKS(4),
        .PRESC_RST(16'd7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step(1);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        step(1);
        read    = 1'b0;
        d       = readdata;
    endtask

    initial begin
        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        in_port   = 8'h00;
        step(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        bus_read(2'd0, rdata); check("rst_deb", rdata, 32'h0);
        bus_read(2'd1, rdata); check("rst_mask", rdata, 32'h0);
        bus_read(2'd2, rdata); check("rst_reload", rdata, 32'h7);
        bus_read(2'd3, rdata); check("rst_edge", rdata, 32'h0);

        // Reload 9: ticks on edges W+10, W+20, W+30, W+40.
        in_port = 8'h04;
        bus_write(2'd2, 32'd9);
        bus_read(2'd2, rdata); check("presc_read", rdata, 32'h9);
        address = 2'd0;
        read    = 1'b1;
        step(39);
        check("presc_deb_early", readdata, 32'h00);
        step(1);
        check("presc_deb_set", readdata, 32'h04);
        read = 1'b0;
        bus_read(2'd3, rdata); check("presc_edge", rdata, 32'h04);
        check("presc_irq_masked", {31'd0, irq}, 32'h0);
        bus_write(2'd3, 32'h04);
        bus_read(2'd3, rdata); check("w1c_edge2", rdata, 32'h00);

        // Reload 0: tick every cycle, debounce takes 2 + 4 edges.
        bus_write(2'd2, 32'd0);
        in_port = 8'h05;
        address = 2'd0;
        read    = 1'b1;
        step(6);
        check("deb_bit0_at6", readdata, 32'h04);
        step(1);
        check("deb_bit0_at7", readdata, 32'h05);
        read = 1'b0;
        bus_read(2'd3, rdata); check("deb_edge0", rdata, 32'h01);

        // Three-cycle glitch on bit 3 never reaches four ticks.
        in_port = 8'h0D;
        step(3);
        in_port = 8'h05;
        step(6);
        bus_read(2'd0, rdata); check("glitch_deb", rdata, 32'h05);
        bus_read(2'd3, rdata); check("glitch_edge", rdata, 32'h01);
        check("glitch_irq", {31'd0, irq}, 32'h0);

        // Interrupt path on a rising debounced bit 0.
        in_port = 8'h04;
        step(8);
        bus_write(2'd3, 32'h01);
        bus_read(2'd3, rdata); check("irq_pre_edge", rdata, 32'h00);
        bus_write(2'd1, 32'h01);
        bus_read(2'd1, rdata); check("irq_mask_read", rdata, 32'h01);
        check("irq_idle", {31'd0, irq}, 32'h0);
        in_port = 8'h05;
        step(6);
        check("irq_same_cycle", {31'd0, irq}, 32'h0);
        step(1);
        check("irq_rise", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h01);
        check("irq_lag_clear", {31'd0, irq}, 32'h1);
        step(1);
        check("irq_fall", {31'd0, irq}, 32'h0);

        // Clear of bit 1 lands on the same edge bit 1 toggles.
        in_port = 8'h07;
        step(5);
        address   = 2'd3;
        writedata = 32'h02;
        write     = 1'b1;
        step(1);
        write = 1'b0;
        bus_read(2'd3, rdata); check("collide_edge", rdata, 32'h02);
        bus_read(2'd0, rdata); check("collide_deb", rdata, 32'h07);
        check("collide_irq", {31'd0, irq}, 32'h0);

        // Read and write on the same edge returns the old value.
        address   = 2'd1;
        writedata = 32'hFF;
        read      = 1'b1;
        write     = 1'b1;
        step(1);
        read  = 1'b0;
        write = 1'b0;
        check("rw_old_mask", readdata, 32'h01);
        bus_read(2'd1, rdata); check("rw_new_mask", rdata, 32'hFF);
        check("irq_mask_ff", {31'd0, irq}, 32'h1);
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rdata); check("ro_deb", rdata, 32'h07);
        bus_write(2'd2, 32'hFFFF_0000);
        bus_read(2'd2, rdata); check("reload_upper", rdata, 32'h0);
        bus_write(2'd1, 32'hFFFF_FF5A);
        bus_read(2'd1, rdata); check("mask_upper", rdata, 32'h5A);
        address = 2'd0;
        step(3);
        check("rd_hold", readdata, 32'h5A);

        // Reset after three of four differing ticks on bit 4.
        in_port = 8'h17;
        step(5);
        reset = 1'b1;
        #1;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        address = 2'd0;
        read    = 1'b1;
        step(2);
        reset = 1'b0;
        // Ticks at release+8, +16, +24, +32; readdata lags by one edge.
        step(32);
        check("rst_deb_hold", readdata, 32'h00);
        step(1);
        check("rst_deb_set", readdata, 32'h17);
        read = 1'b0;
        bus_read(2'd1, rdata); check("post_rst_mask", rdata, 32'h0);
        bus_read(2'd2, rdata); check("post_rst_reload", rdata, 32'h7);
        bus_read(2'd3, rdata); check("post_rst_edge", rdata, 32'h17);
        check("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce_irq_ctrl.md
SW_DEBOUNCE_IRQ_CTRL -- requirements
Module: sw_debounce_irq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of switch inputs controlled.
REQ-002 Parameter STABLE_TICKS, default 4: consecutive differing sample ticks required to accept a new switch level; legal range 1..15.
REQ-003 Parameter PRESC_RST, default 16'd999: reset value of the prescaler reload register.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port address, input, 2: Avalon-MM word address.
REQ-007 Port read, input, 1: read strobe.
REQ-008 Port write, input, 1: write strobe.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port readdata, output, 32: registered read data.
REQ-011 Port in_port, input, WIDTH: raw, asynchronous switch levels.
REQ-012 Port irq, output, 1: level interrupt request.

Function
REQ-013 The block SHALL pass in_port through a 2-flop synchronizer; the debouncer uses only the second flop (sync).
REQ-014 A 16-bit prescaler SHALL count down from the reload value; a one-cycle tick SHALL occur when it equals 0, and the counter SHALL then reload.
REQ-015 On a write to address 2, writedata[15:0] SHALL update the reload value and the prescaler counter SHALL load the new value on the same edge.
REQ-016 Reload 0 SHALL produce a tick every cycle.
REQ-017 Each bit SHALL have a 4-bit stability counter that is evaluated only on ticks.
REQ-018 On a tick, if the sync bit equals the debounced bit, the stability counter SHALL clear to 0.
REQ-019 On a tick, if the sync bit differs and counter+1 equals STABLE_TICKS, the debounced bit SHALL toggle and the counter SHALL clear.
REQ-020 On a tick, if the sync bit differs and counter+1 does not equal STABLE_TICKS, the counter SHALL increment.
REQ-021 Each debounced-bit change, rising or falling, SHALL set the corresponding edge-capture bit in the same cycle.
REQ-022 Register map, address 0, read-only: debounced[WIDTH-1:0], zero-extended; writes are ignored.
REQ-023 Register map, address 1, read/write: irq mask[WIDTH-1:0].
REQ-024 Register map, address 2, read/write: prescaler reload[15:0].
REQ-025 Register map, address 3, read/write-1-to-clear: edge capture[WIDTH-1:0].
REQ-026 Unused readdata bits SHALL read as 0.
REQ-027 Read latency SHALL be 1 cycle: readdata is registered on the edge where read=1 and holds its value while read=0.
REQ-028 If a write-1-to-clear and a new edge hit the same edge-capture bit in the same cycle, the bit SHALL stay set.
REQ-029 irq SHALL be registered and equal |(edge_capture & mask) one cycle after either operand changes.
REQ-030 A simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-031 While reset=1, the following SHALL be forced:
- readdata=0, irq=0, mask=0, edge capture=0;
- debounced=0, stability counters=0, synchronizer flops=0;
- reload=PRESC_RST, prescaler counter=PRESC_RST.
REQ-032 Reset asserted mid-debounce SHALL discard partial counts; after release, debouncing restarts from debounced=0.
REQ-033 After reset release, the first tick SHALL occur PRESC_RST+1 cycles later.

Verification
REQ-034 Debounce: reload=0, STABLE_TICKS=4, in_port[0] 0->1 held -> debounced[0]=1 exactly 2 (sync) + 4 cycles later; edge[0]=1.
REQ-035 Glitch: reload=0, in_port[3] high for 3 cycles then low -> debounced[3] stays 0, edge[3] stays 0, irq stays 0.
REQ-036 IRQ path: mask=0x01 -> debounced[0] rises -> irq=1 next cycle; write 0x01 to address 3 -> irq=0 one cycle after edge clears.
REQ-037 Clear/set collision: write 0x02 to address 3 in the same cycle debounced[1] toggles -> edge[1] reads 1.
REQ-038 Prescaler: write 9 to address 2 -> ticks exactly every 10 cycles; read address 2 returns 0x00000009.
REQ-039 Reset mid-count: assert reset after 3 of 4 differing ticks, release with input still high -> debounced stays 0 for 4 further ticks, then becomes 1.
